// File: rtl/image_streamer.sv
// Raster-scan BRAM reader: streams one stored image as (data, x, y, valid) beats,
// carrying the coordinates alongside each read to cover the BRAM read latency.
module image_streamer #(
    parameter int unsigned BIT_DEPTH    = 8,
    parameter int unsigned WIDTH        = 64,
    parameter int unsigned HEIGHT       = 64,
    parameter int unsigned BRAM_LATENCY = 2,
    localparam int unsigned ADDR_W      = (WIDTH * HEIGHT > 1) ? $clog2(WIDTH * HEIGHT) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 start_in,
    output logic [ADDR_W-1:0]    read_addr_out,
    input  logic [BIT_DEPTH-1:0] bram_data_in,
    output logic [BIT_DEPTH-1:0] data_out,
    output logic [7:0]           data_x_out,
    output logic [7:0]           data_y_out,
    output logic                 data_valid_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam int unsigned CW  = 8;
    localparam int unsigned DW  = (BRAM_LATENCY + 1 > 1) ? $clog2(BRAM_LATENCY + 1) : 1;
    localparam logic [CW-1:0] X_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] Y_MAX = CW'(HEIGHT - 1);
    localparam logic [DW-1:0] DRAIN_LAST = DW'(BRAM_LATENCY);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   x_cnt;
    logic [CW-1:0]   y_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            last_issue_c;
    logic            load_c;
    logic            advance_c;
    logic [CW-1:0]   x_nxt_c;
    logic [CW-1:0]   y_nxt_c;
    logic [ADDR_W-1:0] addr_nxt_c;

    logic            v_pipe [BRAM_LATENCY];
    logic [CW-1:0]   x_pipe [BRAM_LATENCY];
    logic [CW-1:0]   y_pipe [BRAM_LATENCY];

    assign last_issue_c = (x_cnt == X_MAX) && (y_cnt == Y_MAX);

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_in) state_next = SCAN;
            SCAN:    if (last_issue_c) state_next = DRAIN;
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Scan-control decode: frame load, raster advance and the next coordinate/address
    always_comb begin
        load_c     = 1'b0;
        advance_c  = 1'b0;
        x_nxt_c    = x_cnt;
        y_nxt_c    = y_cnt;
        if (state == IDLE && start_in) begin
            load_c = 1'b1;
        end
        if (state == SCAN && !last_issue_c) begin
            advance_c = 1'b1;
            if (x_cnt == X_MAX) begin
                x_nxt_c = '0;
                y_nxt_c = y_cnt + CW'(1);
            end else begin
                x_nxt_c = x_cnt + CW'(1);
            end
        end
        addr_nxt_c = ADDR_W'(y_nxt_c) * ADDR_W'(WIDTH) + ADDR_W'(x_nxt_c);
    end

    // Read issue: coordinate counters, BRAM address, drain counter and busy flag
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            x_cnt         <= '0;
            y_cnt         <= '0;
            read_addr_out <= '0;
            drain_cnt     <= '0;
            busy_out      <= 1'b0;
        end else begin
            if (load_c) begin
                x_cnt         <= '0;
                y_cnt         <= '0;
                read_addr_out <= '0;
            end else if (advance_c) begin
                x_cnt         <= x_nxt_c;
                y_cnt         <= y_nxt_c;
                read_addr_out <= addr_nxt_c;
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + DW'(1) : '0;
            busy_out  <= (state_next != IDLE);
        end
    end

    // Delay line carrying issue-valid and coordinates while the BRAM read is in flight
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < BRAM_LATENCY; i++) begin
                v_pipe[i] <= 1'b0;
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
            end
        end else begin
            v_pipe[0] <= (state == SCAN);
            x_pipe[0] <= x_cnt;
            y_pipe[0] <= y_cnt;
            for (int i = 1; i < BRAM_LATENCY; i++) begin
                v_pipe[i] <= v_pipe[i-1];
                x_pipe[i] <= x_pipe[i-1];
                y_pipe[i] <= y_pipe[i-1];
            end
        end
    end

    // Output register: captures BRAM data with its coordinates; payload holds when idle
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            data_out       <= '0;
            data_x_out     <= '0;
            data_y_out     <= '0;
            data_valid_out <= 1'b0;
            done_out       <= 1'b0;
        end else begin
            data_valid_out <= v_pipe[BRAM_LATENCY-1];
            done_out       <= v_pipe[BRAM_LATENCY-1]
                              && (x_pipe[BRAM_LATENCY-1] == X_MAX)
                              && (y_pipe[BRAM_LATENCY-1] == Y_MAX);
            if (v_pipe[BRAM_LATENCY-1]) begin
                data_out   <= bram_data_in;
                data_x_out <= x_pipe[BRAM_LATENCY-1];
                data_y_out <= y_pipe[BRAM_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_image_streamer.sv
// Bench for image_streamer: random image contents, a queue of expected beats per
// accepted frame (with their expected cycles), and a small second instance (L=1, 8x8).
module tb_image_streamer;

    localparam int unsigned NPIX_A = 64 * 64;
    localparam int unsigned NPIX_B = 8 * 8;

    typedef struct {
        int x;
        int y;
        int d;
        int cyc;
        bit last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [11:0] addr_a;
    logic [5:0]  addr_b;
    logic [7:0]  bram_a;
    logic [7:0]  bram_b;
    logic [7:0]  data_a, data_b;
    logic [7:0]  x_a, y_a, x_b, y_b;
    logic        valid_a, valid_b, busy_a, busy_b, done_a, done_b;

    logic [7:0]  mem_a [NPIX_A];
    logic [7:0]  mem_b [NPIX_B];
    logic [11:0] addr_a_q1;

    int    cyc = 0;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;
    beat_t q[$];
    int    busy_lo = 1;
    int    busy_hi = 0;
    int    idle_from = 0;
    int    beats_a = 0;
    int    dones_a = 0;

    image_streamer dut_a (
        .clk_in(clk), .rst_in(rst), .start_in(start_a),
        .read_addr_out(addr_a), .bram_data_in(bram_a),
        .data_out(data_a), .data_x_out(x_a), .data_y_out(y_a),
        .data_valid_out(valid_a), .busy_out(busy_a), .done_out(done_a)
    );

    image_streamer #(.BIT_DEPTH(8), .WIDTH(8), .HEIGHT(8), .BRAM_LATENCY(1)) dut_b (
        .clk_in(clk), .rst_in(rst), .start_in(start_b),
        .read_addr_out(addr_b), .bram_data_in(bram_b),
        .data_out(data_b), .data_x_out(x_b), .data_y_out(y_b),
        .data_valid_out(valid_b), .busy_out(busy_b), .done_out(done_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // BRAM models: two-cycle read for A, one-cycle read for B
    always @(posedge clk) begin
        addr_a_q1 <= addr_a;
        bram_a    <= mem_a[addr_a_q1];
        bram_b    <= mem_b[addr_b];
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // Pulse start on A; the model accepts it only when the streamer is idle
    task automatic start_a_pulse();
        int s;
        s = cyc;
        start_a = 1'b1;
        if (s >= idle_from) begin
            for (int i = 0; i < int'(NPIX_A); i++) begin
                beat_t b;
                b.x = i % 64;
                b.y = i / 64;
                b.d = int'(mem_a[i]);
                b.cyc = s + 4 + i;
                b.last = (i == int'(NPIX_A) - 1);
                q.push_back(b);
            end
            busy_lo   = s + 1;
            busy_hi   = s + 3 + int'(NPIX_A);
            idle_from = s + 4 + int'(NPIX_A);
        end
        step();
        start_a = 1'b0;
    endtask

    // Stream monitor for A: every cycle checks busy, and each beat against the expected queue
    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("busy_a", int'(busy_a), int'(cyc >= busy_lo && cyc <= busy_hi));
            if (valid_a) begin
                beats_a++;
                if (done_a) dones_a++;
                if (q.size() == 0) begin
                    check_eq("unexpected_beat_valid", int'(valid_a), 0);
                end else begin
                    beat_t b;
                    b = q.pop_front();
                    check_eq("beat_cycle", cyc, b.cyc);
                    check_eq("beat_x", int'(x_a), b.x);
                    check_eq("beat_y", int'(y_a), b.y);
                    check_eq("beat_data", int'(data_a), b.d);
                    check_eq("beat_done", int'(done_a), int'(b.last));
                end
            end else begin
                check_eq("done_without_valid", int'(done_a), 0);
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    check_eq("missing_beat_valid", int'(valid_a), 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        int s1, s3, r, off, gap, sb, nb, exp_beats;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < int'(NPIX_A); i++) mem_a[i] = 8'($urandom);
        for (int i = 0; i < int'(NPIX_B); i++) mem_b[i] = 8'($urandom);

        repeat (3) step();
        check_eq("rst_valid_a", int'(valid_a), 0);
        check_eq("rst_busy_a", int'(busy_a), 0);
        check_eq("rst_done_a", int'(done_a), 0);
        check_eq("rst_addr_a", int'(addr_a), 0);
        check_eq("rst_data_a", int'(data_a), 0);
        check_eq("rst_xy_a", int'({x_a, y_a}), 0);
        check_eq("rst_valid_b", int'(valid_b), 0);
        check_eq("rst_busy_b", int'(busy_b), 0);

        rst = 1'b0;
        step();
        idle_from = cyc;
        mon_en = 1'b1;
        step();

        // Frame 1 with an ignored restart, then a back-to-back frame 2
        s1 = cyc;
        start_a_pulse();
        wait_until(s1 + $urandom_range(500, 3500));
        start_a_pulse();
        wait_until(s1 + 4 + int'(NPIX_A));
        start_a_pulse();
        wait_until(s1 + 2 * (4 + int'(NPIX_A)) + 5);

        // Frame 3 aborted by reset mid-stream
        s3 = cyc;
        start_a_pulse();
        off = $urandom_range(1500, 2500);
        wait_until(s3 + off);
        r = cyc;
        rst = 1'b1;
        step();
        rst = 1'b0;
        q.delete();
        busy_lo = 1;
        busy_hi = 0;
        idle_from = cyc;
        check_eq("abort_valid", int'(valid_a), 0);
        check_eq("abort_done", int'(done_a), 0);
        check_eq("abort_busy", int'(busy_a), 0);
        check_eq("abort_data", int'(data_a), 0);
        check_eq("abort_xy", int'({x_a, y_a}), 0);
        check_eq("abort_addr", int'(addr_a), 0);

        // Frame 4 after a random idle gap
        gap = $urandom_range(3, 20);
        repeat (gap) step();
        start_a_pulse();
        wait_until(cyc + int'(NPIX_A) + 10);

        exp_beats = 3 * int'(NPIX_A) + (r - (s3 + 4) + 1);
        check_eq("total_beats_a", beats_a, exp_beats);
        check_eq("total_dones_a", dones_a, 3);
        check_eq("queue_drained_a", q.size(), 0);
        mon_en = 1'b0;

        // Instance B: latency 1, 8x8 image
        step();
        sb = cyc;
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        nb = 0;
        for (int k = 0; k < 75; k++) begin
            if (valid_b) begin
                check_eq("b_cycle", cyc, sb + 3 + nb);
                check_eq("b_x", int'(x_b), nb % 8);
                check_eq("b_y", int'(y_b), nb / 8);
                check_eq("b_data", int'(data_b), int'(mem_b[nb % int'(NPIX_B)]));
                check_eq("b_done", int'(done_b), int'(nb == int'(NPIX_B) - 1));
                nb++;
            end else begin
                check_eq("b_done_idle", int'(done_b), 0);
            end
            if (cyc == sb + 66) check_eq("b_busy_last", int'(busy_b), 1);
            if (cyc == sb + 67) check_eq("b_busy_after", int'(busy_b), 0);
            step();
        end
        check_eq("b_total_beats", nb, int'(NPIX_B));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/image_streamer.md
Name: image_streamer

Overview:
- Raster-scan reader for the SIFT pyramid datapath.
- On a start pulse, reads a stored octave image out of a single-port BRAM, one address per cycle.
- Emits a pixel stream (data, x, y, valid) that feeds the image_half downsampler and the other per-pixel stages directly.
- Hides BRAM read latency by delaying the coordinates alongside each read.

Parameters:
- BIT_DEPTH, 8: pixel width in bits.
- WIDTH, 64: image width in pixels (x range 0..WIDTH-1); must be ≤ 256.
- HEIGHT, 64: image height in pixels (y range 0..HEIGHT-1); must be ≤ 256.
- BRAM_LATENCY, 2: cycles from address presented to data valid on bram_data_in; must be ≥ 1.

Ports:
- clk_in, input, 1: system clock.
- rst_in, input, 1: synchronous active-high reset.
- start_in, input, 1: single-cycle request to stream one full frame.
- read_addr_out, output, $clog2(WIDTH*HEIGHT): BRAM read address (12 bits at defaults).
- bram_data_in, input, BIT_DEPTH: BRAM read data.
- data_out, output, BIT_DEPTH: streamed pixel value.
- data_x_out, output, 8: pixel column.
- data_y_out, output, 8: pixel row.
- data_valid_out, output, 1: data_out/data_x_out/data_y_out valid this cycle.
- busy_out, output, 1: frame in progress.
- done_out, output, 1: one-cycle pulse with the last pixel of a frame.

Behaviour:
- Reset (one cycle on clk_in with rst_in high):
  - All outputs go to 0.
  - x/y counters and the latency delay line clear.
  - FSM enters IDLE.
  - Reset mid-frame aborts the scan; no further data_valid_out or done_out from that frame.
- FSM states: IDLE, SCAN, DRAIN.
- IDLE: start_in high at the clock edge transitions to SCAN. On that same edge: read_addr_out<=0, x=0, y=0, issue-valid<=1, busy_out<=1.
- SCAN: one read issued per cycle.
  - read_addr_out = y*WIDTH + x, computed at full address width with no truncation.
  - x increments each cycle; at x=WIDTH-1, x wraps to 0 and y increments.
  - When (WIDTH-1, HEIGHT-1) is issued, the next edge enters DRAIN and issue-valid drops.
  - read_addr_out holds its last value in DRAIN and IDLE.
- DRAIN: counts the BRAM_LATENCY+1 cycles needed to flush the delay line, then returns to IDLE.
- Delay line: issue-valid, x and y are shifted through a BRAM_LATENCY-deep register chain.
- Output timing:
  - Address A driven on read_addr_out in cycle k produces its data on bram_data_in in cycle k+BRAM_LATENCY.
  - The block registers it, so data_out=pixel[A] with data_valid_out=1 and matching x/y appear in cycle k+BRAM_LATENCY+1.
  - Total latency from start_in sampled (cycle 0) to first valid output is BRAM_LATENCY+2 cycles (cycle 4 at defaults).
- Stream shape:
  - Exactly WIDTH*HEIGHT valid beats per frame, on consecutive cycles, in raster order (x fastest), with no gaps.
  - data_out, data_x_out and data_y_out hold their last values when invalid; consumers must qualify them with data_valid_out.
- done_out is high in the same cycle as the last valid beat (x=WIDTH-1, y=HEIGHT-1) and is 0 otherwise.
- busy_out:
  - High from cycle 1 after start through the last valid beat inclusive.
  - Low the cycle after done_out.
- start_in while busy_out=1 (SCAN or DRAIN) is ignored and not queued.
- start_in in the cycle right after done_out, with FSM in IDLE, is accepted; back-to-back frames are legal.
- Width rules: x and y are zero-extended into the 8-bit output ports.

Test Plan:
- Basic frame: BRAM model (L=2) with mem[a]=a[7:0]; reset, pulse start_in at cycle 0 -> first beat in cycle 4 with data_out=0x00, x=0, y=0; 4096 consecutive valid beats.
- Raster order: same run -> each beat has data_out=(y*64+x)[7:0]; beat 64 has x=0, y=1, data 0x40; last beat has x=63, y=63, data 0xFF; done_out high only with it.
- busy/done framing: busy_out high cycles 1..4099; done_out at cycle 4099; busy_out=0 at cycle 4100.
- Ignored restart: pulse start_in again at cycle 1000 -> stream unaffected, still exactly 4096 beats, single done_out.
- Back-to-back: start_in at cycle 4100 -> second frame's first beat at cycle 4104 with x=0, y=0; 8192 total beats.
- Reset mid-frame: assert rst_in at cycle 2000 -> from cycle 2001 all outputs are 0 and no done_out; a new start_in then yields a full 4096-beat frame from (0,0).
- Latency parameter: rerun basic frame with BRAM_LATENCY=1 and WIDTH=HEIGHT=8 -> first beat in cycle 3, 64 beats, done_out in cycle 66.
